// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port (inst / data) arbiter onto a single SRAM-like
// memory port. One transaction outstanding at a time; data wins contention
// unless inst has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  // fetch port
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_cancel,
  output logic                inst_addr_ok,
  output logic                inst_valid_f,
  output logic [DATA_W-1:0]   inst_rdata_f,
  // load/store port
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok_m,
  output logic [DATA_W-1:0]   data_rdata_m,
  // downstream memory
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SW     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t              r_state, w_next;
  logic                r_owner_data;   // 1: data port owns the transaction
  logic                r_drop;         // fetch cancelled, suppress its response
  logic [SW-1:0]       r_starve;
  logic                r_wr;
  logic [STRB_W-1:0]   r_wstrb;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_inst_rdata;
  logic [DATA_W-1:0]   r_data_rdata;

  logic w_idle, w_inst_cand, w_starved, w_grant_inst, w_grant_data;

  // A fetch raised together with its own cancel is not a candidate.
  assign w_idle       = (r_state == S_IDLE);
  assign w_inst_cand  = inst_req & ~inst_cancel;
  assign w_starved    = (r_starve == SW'(STARVE_LIMIT));
  // Grants are gated by resetn so no addr_ok leaks out while held in reset.
  assign w_grant_inst = resetn & w_idle & w_inst_cand & (~data_req | w_starved);
  assign w_grant_data = resetn & w_idle & data_req & ~(w_inst_cand & w_starved);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; mem_data_ok only counts once we are in DATA
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_grant_inst | w_grant_data) w_next = S_ADDR;
      S_ADDR: if (mem_addr_ok)                 w_next = S_DATA;
      S_DATA: if (mem_data_ok)                 w_next = S_RESP;
      S_RESP:                                  w_next = S_IDLE;
      default:                                 w_next = S_IDLE;
    endcase
  end

  // Output logic: handshakes and one-cycle response strobes
  always_comb begin
    inst_addr_ok   = w_grant_inst;
    data_addr_ok   = w_grant_data;
    mem_req        = (r_state == S_ADDR);
    inst_valid_f   = (r_state == S_RESP) & ~r_owner_data & ~r_drop & ~inst_cancel;
    data_data_ok_m = (r_state == S_RESP) & r_owner_data;
  end

  // Latch the winner's request fields at acceptance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner_data <= 1'b0;
      r_wr         <= 1'b0;
      r_wstrb      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_grant_data) begin
      r_owner_data <= 1'b1;
      r_wr         <= data_wr;
      r_wstrb      <= data_wstrb;
      r_addr       <= data_addr;
      r_wdata      <= data_wdata;
    end else if (w_grant_inst) begin
      r_owner_data <= 1'b0;
      r_wr         <= 1'b0;
      r_wstrb      <= '0;
      r_addr       <= inst_addr;
      r_wdata      <= '0;
    end
  end

  // Starvation counter: counts data grants that passed over a waiting fetch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                       r_starve <= '0;
    else if (w_grant_inst)                             r_starve <= '0;
    else if (w_grant_data & inst_req & ~w_starved)     r_starve <= r_starve + SW'(1);
  end

  // Drop flag: a fetch cancelled after acceptance still runs on the bus
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                         r_drop <= 1'b0;
    else if (r_state == S_RESP)                          r_drop <= 1'b0;
    else if (!w_idle && !r_owner_data && inst_cancel)    r_drop <= 1'b1;
  end

  // Capture read data into the owner's response register; others hold
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else if (r_state == S_DATA && mem_data_ok) begin
      if (r_owner_data)                 r_data_rdata <= mem_rdata;
      else if (!r_drop && !inst_cancel) r_inst_rdata <= mem_rdata;
    end
  end

  assign mem_wr       = r_wr;
  assign mem_wstrb    = r_wstrb;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign inst_rdata_f = r_inst_rdata;
  assign data_rdata_m = r_data_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32: data width of all ports.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: consecutive contended data grants before inst is forced to win.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port inst_req  input  1  fetch request, held until inst_addr_ok.
REQ-007 SHALL have port inst_addr  input  ADDR_W  fetch address.
REQ-008 SHALL have port inst_cancel  input  1  abandon the accepted fetch.
REQ-009 SHALL have port inst_addr_ok  output  1  fetch accepted this cycle.
REQ-010 SHALL have port inst_valid_f  output  1  one-cycle fetch response strobe.
REQ-011 SHALL have port inst_rdata_f  output  DATA_W  fetch data, valid with inst_valid_f.
REQ-012 SHALL have port data_req  input  1  load/store request, held until data_addr_ok.
REQ-013 SHALL have ports data_wr (1), data_wstrb (DATA_W/8), data_addr (ADDR_W), data_wdata (DATA_W), all inputs: data request fields.
REQ-014 SHALL have port data_addr_ok  output  1  data request accepted this cycle.
REQ-015 SHALL have port data_data_ok_m  output  1  one-cycle data response strobe (loads and stores).
REQ-016 SHALL have port data_rdata_m  output  DATA_W  load data, valid with data_data_ok_m.
REQ-017 SHALL have downstream outputs mem_req (1), mem_wr (1), mem_wstrb (DATA_W/8), mem_addr (ADDR_W), mem_wdata (DATA_W).
REQ-018 SHALL have downstream inputs mem_addr_ok (1), mem_data_ok (1), mem_rdata (DATA_W).

Function
REQ-019 SHALL implement states IDLE, ADDR, DATA, RESP with at most one transaction outstanding.
REQ-020 In IDLE, a pending request SHALL be accepted combinationally: the winner's *_addr_ok is 1 that cycle, its fields are latched, owner is recorded, and the next state is ADDR.
REQ-021 Inst fetches SHALL latch mem_wr=0 and mem_wstrb=0.
REQ-022 The winner SHALL be data when only data_req is 1, inst when only inst_req is 1, and data on contention, unless the starve counter equals STARVE_LIMIT, in which case inst wins.
REQ-023 The starve counter SHALL increment on a data grant while inst_req=1, saturate at STARVE_LIMIT, and clear on any inst grant.
REQ-024 An inst_req asserted with inst_cancel=1 in the same IDLE cycle SHALL NOT be accepted.
REQ-025 In ADDR, mem_req SHALL be 1 with the latched fields driven; on mem_addr_ok=1 the state SHALL move to DATA.
REQ-026 In DATA, on mem_data_ok=1 the arbiter SHALL register mem_rdata and move to RESP.
REQ-027 A mem_data_ok seen in the same cycle as mem_addr_ok SHALL be ignored; only DATA-state data_ok counts.
REQ-028 In RESP, exactly one strobe SHALL be driven for one cycle: data_data_ok_m for a data owner, inst_valid_f for an inst owner that is not dropped. The registered data SHALL appear on the owner's rdata. The next state SHALL be IDLE.
REQ-029 No request SHALL be accepted in RESP; acceptance resumes in the following IDLE cycle. Minimum turnaround is therefore 4 cycles from accept to next accept.
REQ-030 inst_cancel=1 in ADDR, DATA or RESP while the owner is inst SHALL set a drop flag. The memory transaction SHALL complete normally, but inst_valid_f SHALL stay 0 for it. The flag SHALL clear on return to IDLE.
REQ-031 inst_cancel SHALL have no effect on a data-owned transaction.
REQ-032 mem_req SHALL be 0 in every state except ADDR; *_addr_ok SHALL be 0 outside IDLE.
REQ-033 Response rdata outputs SHALL hold their last value when their strobe is 0.

Reset
REQ-034 While resetn=0, all of the following SHALL be 0, asynchronously: state (IDLE), owner, drop flag, starve counter, all latched fields, mem_req, inst_addr_ok, data_addr_ok, inst_valid_f, data_data_ok_m, inst_rdata_f, data_rdata_m.
REQ-035 Reset mid-transaction SHALL abandon it with no response strobe. The first request after resetn rises SHALL be acceptable in the first IDLE cycle.

Verification
REQ-036 Inst only: inst_addr=0x1c000000, mem_addr_ok in the first ADDR cycle, mem_rdata=0x02800400 one cycle later -> inst_valid_f=1 with inst_rdata_f=0x02800400, exactly 3 cycles after inst_addr_ok.
REQ-037 Contention: inst_req and data_req both 1 in IDLE, data_wr=1, data_addr=0x1fd0_0000, data_wstrb=0xF -> data_addr_ok=1, inst_addr_ok=0, mem_wr=1 in ADDR, data_data_ok_m=1 in RESP, inst accepted at the next IDLE.
REQ-038 Starvation: data_req and inst_req both held at 1 with STARVE_LIMIT=4 -> data wins grants 1-4, inst wins grant 5, and the counter reads 0 afterwards.
REQ-039 Cancel: inst accepted, inst_cancel=1 while in DATA, mem_data_ok arrives -> mem handshake completes, inst_valid_f stays 0, next request accepted normally.
REQ-040 Reset: resetn=0 while in DATA -> mem_req=0 and all strobes 0 immediately; after release, a data_req is accepted in the first cycle.
REQ-041 Backpressure: mem_addr_ok held at 0 for 5 cycles -> mem_req and mem_addr held stable for those 5 cycles, and no *_addr_ok is asserted.
